// File: rtl/uart_ctrl_fsm.sv
// UART control sequencer: launches TX from the SEND bit, captures RX bytes,
// and writes status back through the register's low-priority port with loss detection.
module uart_ctrl_fsm #(
  parameter int N            = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] control_i,
  input  logic [7:0]   tx_data_i,
  input  logic         tx_busy_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         tx_start_o,
  output logic [7:0]   tx_data_o,
  output logic [7:0]   rx_data_o,
  output logic         rx_we_o,
  output logic [N-1:0] ctrl_o,
  output logic         ctrl_we_o
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CLR_SEND  = 3'd4;
  localparam logic [2:0] S_RX_WB     = 3'd5;
  localparam logic [2:0] S_RX_CHK    = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_rx_buf;
  logic [7:0]       r_rx_data;
  logic [7:0]       w_buf_next;
  logic             r_pending;
  logic             r_ovr;
  logic             r_ovr_wb;
  logic             r_retry;
  logic             w_first_wb;

  assign w_timeout  = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));
  // A retry pass through RX_WB only repeats the control write, never the data write.
  assign w_first_wb = (r_state == S_RX_WB) && !r_retry;
  assign w_buf_next = rx_valid_i ? rx_data_i : r_rx_buf;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_next = S_RX_WB;
        end else if (control_i[0]) begin
          w_next = S_START;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_START: w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          w_next = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_next = S_CLR_SEND;
        end else begin
          w_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          w_next = S_CLR_SEND;
        end else begin
          w_next = S_WAIT_DONE;
        end
      end
      S_CLR_SEND: w_next = S_IDLE;
      S_RX_WB:    w_next = S_RX_CHK;
      S_RX_CHK: begin
        if (control_i[1]) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RX_WB;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY && !tx_busy_i && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_IDLE && w_next == S_START) begin
        r_tx_data <= tx_data_i;
      end
    end
  end

  // RX capture runs in every state; a byte landing while the previous one is still unwritten is an overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_buf  <= 8'h00;
      r_rx_data <= 8'h00;
      r_pending <= 1'b0;
      r_ovr     <= 1'b0;
      r_ovr_wb  <= 1'b0;
      r_retry   <= 1'b0;
    end else begin
      if (rx_valid_i) begin
        r_rx_buf  <= rx_data_i;
        r_pending <= 1'b1;
        r_ovr     <= w_first_wb ? 1'b0 : (r_ovr | r_pending);
      end else if (w_first_wb) begin
        r_pending <= 1'b0;
        r_ovr     <= 1'b0;
      end
      if (r_state == S_IDLE && r_pending) begin
        r_rx_data <= w_buf_next;
      end
      if (w_first_wb) begin
        r_ovr_wb <= r_ovr;
      end
      if (r_state == S_RX_CHK) begin
        r_retry <= ~control_i[1];
      end
    end
  end

  always_comb begin
    ctrl_o = '0;
    case (r_state)
      S_CLR_SEND: ctrl_o = {control_i[N-1:1], 1'b0};
      S_RX_WB: begin
        ctrl_o    = control_i;
        ctrl_o[1] = 1'b1;
        ctrl_o[2] = control_i[2] | (r_retry ? r_ovr_wb : r_ovr);
      end
      default: ctrl_o = '0;
    endcase
  end

  assign tx_start_o = (r_state == S_START);
  assign rx_we_o    = w_first_wb;
  assign ctrl_we_o  = (r_state == S_CLR_SEND) || (r_state == S_RX_WB);
  assign tx_data_o  = r_tx_data;
  assign rx_data_o  = r_rx_data;

endmodule

// File: tb/tb_uart_ctrl_fsm.sv
// Bench for uart_ctrl_fsm: a control-register model with bus priority, and an
// expected-event scoreboard (cycle + value per strobe) checked on every falling edge.
module tb_uart_ctrl_fsm;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_reg;
  logic [7:0]  tx_data_i;
  logic        tx_busy_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic [7:0]  rx_data_o;
  logic        rx_we_o;
  logic [31:0] ctrl_o;
  logic        ctrl_we_o;

  logic        bus_we;
  logic [31:0] bus_val;
  int          drop_req;
  int          dropped_n = 0;
  int          cyc = 0;
  int          n_checks;
  int          n_err;
  ev_t         q_txs[$];
  ev_t         q_rxw[$];
  ev_t         q_cw[$];
  int          s;

  uart_ctrl_fsm #(.N(32), .BUSY_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .control_i(ctrl_reg),
    .tx_data_i(tx_data_i), .tx_busy_i(tx_busy_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .rx_data_o(rx_data_o), .rx_we_o(rx_we_o),
    .ctrl_o(ctrl_o), .ctrl_we_o(ctrl_we_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Control register: bus port wins; WR2 writes can be deliberately dropped.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg <= 32'h0;
    end else if (bus_we) begin
      ctrl_reg <= bus_val;
    end else if (ctrl_we_o) begin
      if (dropped_n < drop_req) dropped_n <= dropped_n + 1;
      else ctrl_reg <= ctrl_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] v);
    bus_we  = 1'b1;
    bus_val = v;
    tick(1);
    bus_we  = 1'b0;
  endtask

  task automatic exp_txs(input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c; e.val = v; q_txs.push_back(e);
  endtask

  task automatic exp_rxw(input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c; e.val = v; q_rxw.push_back(e);
  endtask

  task automatic exp_cw(input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c; e.val = v; q_cw.push_back(e);
  endtask

  task automatic chk_drained(input string nm);
    chk(nm, 32'(q_txs.size() + q_rxw.size() + q_cw.size()), 32'd0);
  endtask

  task automatic monitor();
    logic p_txs;
    logic p_rxw;
    logic p_cw;
    ev_t  e;
    p_txs = 1'b0; p_rxw = 1'b0; p_cw = 1'b0;
    forever begin
      @(negedge clk);
      if (!ctrl_we_o) chk("ctrl_o_zero_without_we", ctrl_o, 32'h0);
      chk("strobe_back_to_back", {29'd0, p_txs & tx_start_o, p_rxw & rx_we_o, p_cw & ctrl_we_o}, 32'h0);
      if (tx_start_o) begin
        if (q_txs.size() == 0) chk("tx_start_unexpected", {31'd0, tx_start_o}, 32'h0);
        else begin
          e = q_txs.pop_front();
          chk("tx_start_cycle", cyc, e.cyc);
          chk("tx_data", {24'd0, tx_data_o}, e.val);
        end
      end
      if (rx_we_o) begin
        if (q_rxw.size() == 0) chk("rx_we_unexpected", {31'd0, rx_we_o}, 32'h0);
        else begin
          e = q_rxw.pop_front();
          chk("rx_we_cycle", cyc, e.cyc);
          chk("rx_data", {24'd0, rx_data_o}, e.val);
        end
      end
      if (ctrl_we_o) begin
        if (q_cw.size() == 0) chk("ctrl_we_unexpected", {31'd0, ctrl_we_o}, 32'h0);
        else begin
          e = q_cw.pop_front();
          chk("ctrl_we_cycle", cyc, e.cyc);
          chk("ctrl_value", ctrl_o, e.val);
        end
      end
      p_txs = tx_start_o; p_rxw = rx_we_o; p_cw = ctrl_we_o;
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0; drop_req = 0;
    rst = 1'b1; bus_we = 1'b0; bus_val = 32'h0;
    tx_data_i = 8'h00; tx_busy_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    fork
      monitor();
    join_none
    tick(2);
    chk("reset_strobes", {29'd0, tx_start_o, rx_we_o, ctrl_we_o}, 32'h0);
    chk("reset_ctrl_o", ctrl_o, 32'h0);
    chk("reset_tx_data", {24'd0, tx_data_o}, 32'h0);
    chk("reset_rx_data", {24'd0, rx_data_o}, 32'h0);
    rst = 1'b0;
    tick(2);

    // T1: normal send, busy high for 10 cycles
    tx_data_i = 8'h41;
    bus_write(32'h1);
    s = cyc;
    exp_txs(s + 1, 32'h41);
    tick(2);
    tx_busy_i = 1'b1;
    tick(10);
    tx_busy_i = 1'b0;
    exp_cw(cyc + 1, 32'h0);
    tick(4);
    chk_drained("t1_events");
    chk("t1_ctrl_reg", ctrl_reg, 32'h0);
    chk("t1_tx_data_held", {24'd0, tx_data_o}, 32'h41);

    // T2: busy never rises, abandon after 16 cycles waiting
    tx_data_i = 8'h5A;
    bus_write(32'h1);
    s = cyc;
    exp_txs(s + 1, 32'h5A);
    exp_cw(s + 2 + 16, 32'h0);
    tick(22);
    chk_drained("t2_events");
    chk("t2_ctrl_reg", ctrl_reg, 32'h0);

    // T3: received byte written back with RX_NEW
    bus_write(32'hF0);
    s = cyc;
    rx_valid_i = 1'b1; rx_data_i = 8'h55;
    exp_rxw(s + 2, 32'h55);
    exp_cw(s + 2, 32'hF2);
    tick(1);
    rx_valid_i = 1'b0;
    tick(6);
    chk_drained("t3_events");
    chk("t3_ctrl_reg", ctrl_reg, 32'hF2);
    chk("t3_rx_data_held", {24'd0, rx_data_o}, 32'h55);

    // T4: first status write lost to the bus, retried without a second data write
    drop_req = 1;
    bus_write(32'hF0);
    s = cyc;
    rx_valid_i = 1'b1; rx_data_i = 8'h66;
    exp_rxw(s + 2, 32'h66);
    exp_cw(s + 2, 32'hF2);
    exp_cw(s + 4, 32'hF2);
    tick(1);
    rx_valid_i = 1'b0;
    tick(8);
    chk_drained("t4_events");
    chk("t4_ctrl_reg", ctrl_reg, 32'hF2);

    // T5: two bytes arrive during a TX, newest kept and overrun reported
    tx_data_i = 8'h7E;
    bus_write(32'h1);
    s = cyc;
    exp_txs(s + 1, 32'h7E);
    tick(2);
    tx_busy_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b1; rx_data_i = 8'h11;
    tick(1);
    rx_data_i = 8'h22;
    tick(1);
    rx_valid_i = 1'b0;
    tick(3);
    tx_busy_i = 1'b0;
    exp_cw(cyc + 1, 32'h0);
    exp_rxw(cyc + 3, 32'h22);
    exp_cw(cyc + 3, 32'h6);
    tick(6);
    chk_drained("t5_events");
    chk("t5_status_bits", ctrl_reg & 32'h6, 32'h6);
    chk("t5_rx_data", {24'd0, rx_data_o}, 32'h22);

    // T6: reset mid-TX with a byte pending
    tx_data_i = 8'h33;
    bus_write(32'h1);
    s = cyc;
    exp_txs(s + 1, 32'h33);
    tick(2);
    tx_busy_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b1; rx_data_i = 8'h99;
    tick(1);
    rx_valid_i = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("t6_rst_strobes", {29'd0, tx_start_o, rx_we_o, ctrl_we_o}, 32'h0);
    chk("t6_rst_ctrl_o", ctrl_o, 32'h0);
    chk("t6_rst_tx_data", {24'd0, tx_data_o}, 32'h0);
    chk("t6_rst_rx_data", {24'd0, rx_data_o}, 32'h0);
    tx_busy_i = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk_drained("t6_events");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
